// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiply operand front end.
// FP_MUL_DENORM_EN (optional define) keeps denormal operands instead of flushing them to zero.
package fp_mul_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_DENORM,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Unpacked operand as consumed by the multiplier datapath
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              norm;
    } fp_operand_t;

    typedef struct packed {
        fp_operand_t       num1;
        fp_operand_t       num2;
        logic              special;
        logic [WORD_W-1:0] special_result;
    } mul_entry_t;

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational classifier/unpacker for one IEEE754 single word.
// Honours FP_MUL_DENORM_EN: when undefined, denormals classify as zero.
module fp_operand_classify
    import fp_mul_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output fp_class_t         cls,
    output fp_operand_t       fields
);

    logic [EXP_W-1:0]  exp_raw;
    logic [MANT_W-1:0] frac;
    logic              frac_nz;

    assign exp_raw = word[WORD_W-2 -: EXP_W];
    assign frac    = word[MANT_W-1:0];
    assign frac_nz = |frac;

    always_comb begin
        cls         = FP_NORMAL;
        fields.sign = word[WORD_W-1];
        fields.exp  = exp_raw;
        fields.mant = frac;
        fields.norm = 1'b1;
        if (exp_raw == EXP_MAX) begin
            cls = frac_nz ? FP_NAN : FP_INF;
        end else if (exp_raw == '0) begin
            if (!frac_nz) begin
                cls = FP_ZERO;
            end else begin
`ifdef FP_MUL_DENORM_EN
                // Denormal scales as exponent 1 with no hidden bit
                cls         = FP_DENORM;
                fields.exp  = EXP_W'(1);
                fields.norm = 1'b0;
`else
                cls = FP_ZERO;
`endif
            end
        end
    end

endmodule

// File: rtl/fp_mul_operand_stage.sv
// Registered FP multiply front end: unpacks operands, resolves specials, buffers DEPTH entries in order.
// Build option FP_MUL_DENORM_EN is applied inside fp_operand_classify.
module fp_mul_operand_stage
    import fp_mul_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_a,
    input  logic [WORD_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign_num1,
    output logic                out_sign_num2,
    output logic [EXP_W-1:0]    out_exp_num1,
    output logic [EXP_W-1:0]    out_exp_num2,
    output logic [MANT_W-1:0]   out_mantissa_num1,
    output logic [MANT_W-1:0]   out_mantissa_num2,
    output logic                out_normilized_bit_num1,
    output logic                out_normilized_bit_num2,
    output logic                out_special,
    output logic [WORD_W-1:0]   out_special_result,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_state_t;

    occ_state_t       state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] tag_ctr;
    logic             push, pop, prod_sign;

    mul_entry_t       entry_q [DEPTH];
    mul_entry_t       entry_d [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [TAG_W-1:0] tag_d   [DEPTH];

    fp_class_t   cls_a, cls_b;
    fp_operand_t op_a, op_b;
    mul_entry_t  new_entry;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    fp_operand_classify u_classify_a (.word(in_a), .cls(cls_a), .fields(op_a));
    fp_operand_classify u_classify_b (.word(in_b), .cls(cls_b), .fields(op_b));

    // Special-operand resolution, NaN-producing cases first
    always_comb begin
        prod_sign                = in_a[WORD_W-1] ^ in_b[WORD_W-1];
        new_entry.num1           = op_a;
        new_entry.num2           = op_b;
        new_entry.special        = 1'b1;
        new_entry.special_result = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_INF && cls_b == FP_ZERO) ||
            (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            new_entry.special_result = QNAN;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            new_entry.special_result = {prod_sign, EXP_MAX, MANT_W'(0)};
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            new_entry.special_result = {prod_sign, (WORD_W-1)'(0)};
        end else begin
            new_entry.special = 1'b0;
        end
    end

    // Occupancy next state
    always_comb begin
        count_next = count;
        state_next = state;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        if (count_next == '0) begin
            state_next = S_EMPTY;
        end else if (count_next == CNT_W'(DEPTH)) begin
            state_next = S_FULL;
        end else begin
            state_next = S_PARTIAL;
        end
    end

    // Shift-down buffer: slot 0 is always the head, so outputs come straight from flops
    always_comb begin
        entry_d = entry_q;
        tag_d   = tag_q;
        wr_idx  = pop ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_d[i] = entry_q[i+1];
                tag_d[i]   = tag_q[i+1];
            end
        end
        if (push) begin
            entry_d[wr_idx] = new_entry;
            tag_d[wr_idx]   = tag_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            count     <= '0;
            tag_ctr   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            state     <= state_next;
            count     <= count_next;
            entry_q   <= entry_d;
            tag_q     <= tag_d;
            in_ready  <= (state_next != S_FULL);
            out_valid <= (state_next != S_EMPTY);
            if (push) begin
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
        end
    end

    assign out_sign_num1           = entry_q[0].num1.sign;
    assign out_sign_num2           = entry_q[0].num2.sign;
    assign out_exp_num1            = entry_q[0].num1.exp;
    assign out_exp_num2            = entry_q[0].num2.exp;
    assign out_mantissa_num1       = entry_q[0].num1.mant;
    assign out_mantissa_num2       = entry_q[0].num2.mant;
    assign out_normilized_bit_num1 = entry_q[0].num1.norm;
    assign out_normilized_bit_num2 = entry_q[0].num2.norm;
    assign out_special             = entry_q[0].special;
    assign out_special_result      = entry_q[0].special_result;
    assign out_tag                 = tag_q[0];

endmodule

// File: tb/tb_fp_mul_operand_stage.sv
// Directed bench for fp_mul_operand_stage (DEPTH=2, TAG_W=4); inputs driven and outputs sampled on negedge.
module tb_fp_mul_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_num1;
    logic        out_sign_num2;
    logic [7:0]  out_exp_num1;
    logic [7:0]  out_exp_num2;
    logic [22:0] out_mantissa_num1;
    logic [22:0] out_mantissa_num2;
    logic        out_normilized_bit_num1;
    logic        out_normilized_bit_num2;
    logic        out_special;
    logic [31:0] out_special_result;
    logic [3:0]  out_tag;

    int n_vec;
    int n_err;
    int sent;
    int recv;

    fp_mul_operand_stage #(.DEPTH(2), .TAG_W(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_a                    (in_a),
        .in_b                    (in_b),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_sign_num1           (out_sign_num1),
        .out_sign_num2           (out_sign_num2),
        .out_exp_num1            (out_exp_num1),
        .out_exp_num2            (out_exp_num2),
        .out_mantissa_num1       (out_mantissa_num1),
        .out_mantissa_num2       (out_mantissa_num2),
        .out_normilized_bit_num1 (out_normilized_bit_num1),
        .out_normilized_bit_num2 (out_normilized_bit_num2),
        .out_special             (out_special),
        .out_special_result      (out_special_result),
        .out_tag                 (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Offer one pair into an empty stage; returns one cycle after the accepting edge
    task automatic offer(input logic [31:0] a, input logic [31:0] b);
        chk("offer_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("offer_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("take_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; sent = 0; recv = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_special_result", out_special_result, 32'd0);
        chk("rst_exp1", 32'(out_exp_num1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.5 x 2.0
        offer(32'h3FC00000, 32'h40000000);
        chk("t1_sign1", 32'(out_sign_num1), 32'd0);
        chk("t1_sign2", 32'(out_sign_num2), 32'd0);
        chk("t1_exp1", 32'(out_exp_num1), 32'h7F);
        chk("t1_exp2", 32'(out_exp_num2), 32'h80);
        chk("t1_mant1", 32'(out_mantissa_num1), 32'h400000);
        chk("t1_mant2", 32'(out_mantissa_num2), 32'h000000);
        chk("t1_norm1", 32'(out_normilized_bit_num1), 32'd1);
        chk("t1_norm2", 32'(out_normilized_bit_num2), 32'd1);
        chk("t1_special", 32'(out_special), 32'd0);
        chk("t1_tag", 32'(out_tag), 32'd0);
        take();

        // inf x 0 and NaN x 1
        offer(32'h7F800000, 32'h00000000);
        chk("t2_inf_zero_special", 32'(out_special), 32'd1);
        chk("t2_inf_zero_result", out_special_result, 32'h7FC00000);
        chk("t2_inf_zero_exp1", 32'(out_exp_num1), 32'hFF);
        take();
        offer(32'h7FC00001, 32'h3F800000);
        chk("t2_nan_special", 32'(out_special), 32'd1);
        chk("t2_nan_result", out_special_result, 32'h7FC00000);
        chk("t2_nan_mant1", 32'(out_mantissa_num1), 32'h400001);
        take();

        // -inf x 2 and -0 x 1
        offer(32'hFF800000, 32'h40000000);
        chk("t3_inf_special", 32'(out_special), 32'd1);
        chk("t3_inf_result", out_special_result, 32'hFF800000);
        chk("t3_inf_sign1", 32'(out_sign_num1), 32'd1);
        take();
        offer(32'h80000000, 32'h3F800000);
        chk("t3_zero_special", 32'(out_special), 32'd1);
        chk("t3_zero_result", out_special_result, 32'h80000000);
        take();

        // smallest denormal x 1
        offer(32'h00000001, 32'h3F800000);
`ifdef FP_MUL_DENORM_EN
        chk("t4_den_special", 32'(out_special), 32'd0);
        chk("t4_den_exp1", 32'(out_exp_num1), 32'h01);
        chk("t4_den_mant1", 32'(out_mantissa_num1), 32'h000001);
        chk("t4_den_norm1", 32'(out_normilized_bit_num1), 32'd0);
`else
        chk("t4_ftz_special", 32'(out_special), 32'd1);
        chk("t4_ftz_result", out_special_result, 32'h00000000);
        chk("t4_ftz_norm1", 32'(out_normilized_bit_num1), 32'd1);
`endif
        take();

        // Backpressure and ordering, tags restart after reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready0", 32'(in_ready), 32'd1);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        @(negedge clk);
        in_a = 32'h3F800001;
        @(negedge clk);
        chk("t5_full_ready", 32'(in_ready), 32'd0);
        chk("t5_full_tag", 32'(out_tag), 32'd0);
        in_a = 32'h3F800002;
        @(negedge clk);
        chk("t5_blocked_ready", 32'(in_ready), 32'd0);
        chk("t5_hold_tag", 32'(out_tag), 32'd0);
        chk("t5_hold_mant", 32'(out_mantissa_num1), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_pop_tag1", 32'(out_tag), 32'd1);
        chk("t5_pop_mant1", 32'(out_mantissa_num1), 32'd1);
        chk("t5_pop_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("t5_pushpop_tag2", 32'(out_tag), 32'd2);
        chk("t5_pushpop_mant2", 32'(out_mantissa_num1), 32'd2);
        chk("t5_pushpop_valid", 32'(out_valid), 32'd1);
        chk("t5_pushpop_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_drained", 32'(out_valid), 32'd0);

        // 17-op stream, tags continue at 3 and wrap F -> 0
        for (int cyc = 0; cyc < 200 && recv < 17; cyc++) begin
            if (out_valid && out_ready) begin
                chk("stream_tag", 32'(out_tag), 32'((3 + recv) % 16));
                chk("stream_mant", 32'(out_mantissa_num1), 32'(recv));
                recv++;
            end
            if (sent < 17) begin
                in_valid = 1'b1;
                in_a     = 32'h3F800000 + 32'(sent);
                in_b     = 32'h40000000;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", 32'(recv), 32'd17);
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Reset with two entries buffered
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_full_valid", 32'(out_valid), 32'd1);
        chk("t6_full_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        offer(32'h40400000, 32'h3F800000);
        chk("t6_tag_restart", 32'(out_tag), 32'd0);
        chk("t6_exp1", 32'(out_exp_num1), 32'h80);
        chk("t6_mant1", 32'(out_mantissa_num1), 32'h400000);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
